// File: rtl/ex_mem_if.sv
// EX -> MEM pipeline boundary bundle: EX-side inputs, registered MEM outputs,
// the architectural flag register and the B.cond flag bypass.
interface ex_mem_if #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
);
  // Pipeline control
  logic              stall;
  logic              flush;

  // EX-stage instruction
  logic              ex_valid;
  logic [DATA_W-1:0] ex_result;
  logic              ex_negative;
  logic              ex_zero;
  logic              ex_overflow;
  logic              ex_carry_out;
  logic              ex_set_flags;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;

  // Registered EX/MEM state
  logic              mem_valid;
  logic              mem_reg_write;
  logic              mem_mem_read;
  logic              mem_mem_write;
  logic [DATA_W-1:0] mem_result;
  logic [DATA_W-1:0] mem_store_data;
  logic [REG_W-1:0]  mem_rd;

  // Architectural flags and the bypassed view for a B.cond in EX
  logic              flag_n;
  logic              flag_z;
  logic              flag_v;
  logic              flag_c;
  logic              cond_n;
  logic              cond_z;
  logic              cond_v;
  logic              cond_c;

  // Driver of the EX side (pipeline front end / testbench)
  modport master (
    output stall, flush, ex_valid, ex_result, ex_negative, ex_zero,
           ex_overflow, ex_carry_out, ex_set_flags, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write,
    input  mem_valid, mem_reg_write, mem_mem_read, mem_mem_write,
           mem_result, mem_store_data, mem_rd,
           flag_n, flag_z, flag_v, flag_c,
           cond_n, cond_z, cond_v, cond_c
  );

  // The EX/MEM stage itself
  modport slave (
    input  stall, flush, ex_valid, ex_result, ex_negative, ex_zero,
           ex_overflow, ex_carry_out, ex_set_flags, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write,
    output mem_valid, mem_reg_write, mem_mem_read, mem_mem_write,
           mem_result, mem_store_data, mem_rd,
           flag_n, flag_z, flag_v, flag_c,
           cond_n, cond_z, cond_v, cond_c
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with the NZVC condition-flag register.
// Edge priority is reset > flush > stall > load. Flags update only for a
// valid, unsquashed, unstalled flag-setting instruction, and a B.cond in EX
// sees a same-cycle flag-setter through a combinational bypass.
module ex_mem_stage #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic   clk,
  input  logic   reset,
  ex_mem_if.slave bus
);

  logic              r_mem_valid;
  logic              r_mem_reg_write;
  logic              r_mem_mem_read;
  logic              r_mem_mem_write;
  logic [DATA_W-1:0] r_mem_result;
  logic [DATA_W-1:0] r_mem_store_data;
  logic [REG_W-1:0]  r_mem_rd;
  logic [3:0]        r_flags;        // {N, Z, V, C}

  logic [3:0]        w_ex_flags;
  logic              w_ex_sets_flags;
  logic [3:0]        w_cond_flags;

  assign w_ex_flags      = {bus.ex_negative, bus.ex_zero, bus.ex_overflow, bus.ex_carry_out};
  assign w_ex_sets_flags = bus.ex_valid & bus.ex_set_flags;

  // Pipeline register: reset and flush clear to a bubble, stall holds, else load
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_mem_valid      <= 1'b0;
      r_mem_reg_write  <= 1'b0;
      r_mem_mem_read   <= 1'b0;
      r_mem_mem_write  <= 1'b0;
      r_mem_result     <= '0;
      r_mem_store_data <= '0;
      r_mem_rd         <= '0;
    end else if (!bus.stall) begin
      // Control bits are gated by valid so a bubble never writes anything
      r_mem_valid      <= bus.ex_valid;
      r_mem_reg_write  <= bus.ex_reg_write & bus.ex_valid;
      r_mem_mem_read   <= bus.ex_mem_read  & bus.ex_valid;
      r_mem_mem_write  <= bus.ex_mem_write & bus.ex_valid;
      r_mem_result     <= bus.ex_result;
      r_mem_store_data <= bus.ex_store_data;
      r_mem_rd         <= bus.ex_rd;
    end
  end

  // Flag register: commits only for a valid flag-setter that actually advances
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else if (!bus.flush && !bus.stall && w_ex_sets_flags) begin
      r_flags <= w_ex_flags;
    end
  end

  // B.cond bypass: a flag-setter in EX is visible regardless of stall/flush
  always_comb begin
    w_cond_flags = r_flags;
    if (w_ex_sets_flags) begin
      w_cond_flags = w_ex_flags;
    end
  end

  assign bus.mem_valid      = r_mem_valid;
  assign bus.mem_reg_write  = r_mem_reg_write;
  assign bus.mem_mem_read   = r_mem_mem_read;
  assign bus.mem_mem_write  = r_mem_mem_write;
  assign bus.mem_result     = r_mem_result;
  assign bus.mem_store_data = r_mem_store_data;
  assign bus.mem_rd         = r_mem_rd;

  assign bus.flag_n = r_flags[3];
  assign bus.flag_z = r_flags[2];
  assign bus.flag_v = r_flags[1];
  assign bus.flag_c = r_flags[0];

  assign bus.cond_n = w_cond_flags[3];
  assign bus.cond_z = w_cond_flags[2];
  assign bus.cond_v = w_cond_flags[1];
  assign bus.cond_c = w_cond_flags[0];

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed testbench for ex_mem_stage: reset, load, flag bypass, stall,
// flush-over-stall, invalid bubble, mid-stream reset and back-to-back loads.
module tb_ex_mem_stage;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  ex_mem_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  ex_mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.flush = 0; bus.ex_valid = 0; bus.ex_result = '0;
    bus.ex_negative = 0; bus.ex_zero = 0; bus.ex_overflow = 0; bus.ex_carry_out = 0;
    bus.ex_set_flags = 0; bus.ex_store_data = '0; bus.ex_rd = '0;
    bus.ex_reg_write = 0; bus.ex_mem_read = 0; bus.ex_mem_write = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    checks++;
    if ({bus.mem_valid, bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000",
               {bus.mem_valid, bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write});
    end
    checks++;
    if (bus.mem_result !== 64'h0 || bus.mem_store_data !== 64'h0 || bus.mem_rd !== 5'd0) begin
      errors++;
      $display("FAIL reset_data: got result=%h store=%h rd=%0d expected all 0",
               bus.mem_result, bus.mem_store_data, bus.mem_rd);
    end
    checks++;
    if ({bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c});
    end
    reset = 0;
    $display("test_reset done");
  endtask

  task automatic test_load();
    bus.ex_valid = 1; bus.ex_result = 64'h5; bus.ex_rd = 5'd3; bus.ex_reg_write = 1;
    bus.ex_store_data = 64'hAA;
    tick();
    checks++;
    if (bus.mem_result !== 64'h5 || bus.mem_rd !== 5'd3 || bus.mem_store_data !== 64'hAA) begin
      errors++;
      $display("FAIL load_data: got result=%h rd=%0d store=%h expected 5/3/aa",
               bus.mem_result, bus.mem_rd, bus.mem_store_data);
    end
    checks++;
    if ({bus.mem_valid, bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write} !== 4'b1100) begin
      errors++;
      $display("FAIL load_ctrl: got %b expected 1100",
               {bus.mem_valid, bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write});
    end
    $display("test_load done");
  endtask

  task automatic test_flags_bypass();
    // SUBS setting Z and C
    bus.ex_valid = 1; bus.ex_result = 64'h0; bus.ex_set_flags = 1;
    bus.ex_negative = 0; bus.ex_zero = 1; bus.ex_overflow = 0; bus.ex_carry_out = 1;
    #1;
    checks++;
    if ({bus.cond_n, bus.cond_z, bus.cond_v, bus.cond_c} !== 4'b0101) begin
      errors++;
      $display("FAIL bypass_cond: got %b expected 0101", {bus.cond_n, bus.cond_z, bus.cond_v, bus.cond_c});
    end
    checks++;
    if ({bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== 4'b0000) begin
      errors++;
      $display("FAIL bypass_flag_early: got %b expected 0000", {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c});
    end
    tick();
    checks++;
    if ({bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== 4'b0101) begin
      errors++;
      $display("FAIL flag_set: got %b expected 0101", {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c});
    end
    // ADD that does not set flags
    bus.ex_set_flags = 0; bus.ex_zero = 0; bus.ex_carry_out = 0; bus.ex_result = 64'h5;
    #1;
    checks++;
    if ({bus.cond_n, bus.cond_z, bus.cond_v, bus.cond_c} !== 4'b0101) begin
      errors++;
      $display("FAIL cond_from_reg: got %b expected 0101", {bus.cond_n, bus.cond_z, bus.cond_v, bus.cond_c});
    end
    tick();
    checks++;
    if ({bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== 4'b0101 || bus.mem_result !== 64'h5) begin
      errors++;
      $display("FAIL flag_hold_add: got flags=%b result=%h expected 0101/5",
               {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c}, bus.mem_result);
    end
    $display("test_flags_bypass done");
  endtask

  task automatic test_stall();
    logic [63:0] vals [3];
    vals[0] = 64'h7; vals[1] = 64'h8; vals[2] = 64'h9;
    bus.stall = 1; bus.ex_set_flags = 1; bus.ex_negative = 1; bus.ex_zero = 0;
    for (int i = 0; i < 3; i++) begin
      bus.ex_result = vals[i];
      tick();
      checks++;
      if (bus.mem_result !== 64'h5 || {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== 4'b0101) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got result=%h flags=%b expected 5/0101",
                 i, bus.mem_result, {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c});
      end
    end
    bus.stall = 0; bus.ex_set_flags = 0; bus.ex_negative = 0;
    tick();
    checks++;
    if (bus.mem_result !== 64'h9) begin
      errors++;
      $display("FAIL stall_release: got %h expected 9", bus.mem_result);
    end
    $display("test_stall done");
  endtask

  task automatic test_flush_during_stall();
    bus.stall = 1; bus.flush = 1; bus.ex_valid = 1; bus.ex_mem_write = 1;
    bus.ex_set_flags = 1; bus.ex_negative = 1; bus.ex_zero = 0; bus.ex_carry_out = 0;
    bus.ex_result = 64'h77; bus.ex_rd = 5'd9;
    #1;
    checks++;
    if (bus.cond_n !== 1'b1) begin
      errors++;
      $display("FAIL flush_cond_n: got %b expected 1", bus.cond_n);
    end
    tick();
    checks++;
    if ({bus.mem_valid, bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write} !== 4'b0000 ||
        bus.mem_result !== 64'h0 || bus.mem_rd !== 5'd0 || bus.mem_store_data !== 64'h0) begin
      errors++;
      $display("FAIL flush_clear: got ctrl=%b result=%h rd=%0d expected 0000/0/0",
               {bus.mem_valid, bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write},
               bus.mem_result, bus.mem_rd);
    end
    checks++;
    if ({bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== 4'b0101) begin
      errors++;
      $display("FAIL flush_flags: got %b expected 0101", {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c});
    end
    bus.stall = 0; bus.flush = 0;
    $display("test_flush_during_stall done");
  endtask

  task automatic test_bubble();
    idle_inputs();
    bus.ex_valid = 1; bus.ex_reg_write = 1; bus.ex_result = 64'h11; bus.ex_rd = 5'd4;
    tick();
    checks++;
    if (bus.mem_reg_write !== 1'b1) begin
      errors++;
      $display("FAIL bubble_pre: got %b expected 1", bus.mem_reg_write);
    end
    bus.ex_valid = 0; bus.ex_reg_write = 1; bus.ex_mem_write = 1; bus.ex_mem_read = 1;
    bus.ex_set_flags = 1; bus.ex_negative = 1; bus.ex_result = 64'h22; bus.ex_rd = 5'd6;
    #1;
    checks++;
    if ({bus.cond_n, bus.cond_z, bus.cond_v, bus.cond_c} !== 4'b0101) begin
      errors++;
      $display("FAIL bubble_cond: got %b expected 0101", {bus.cond_n, bus.cond_z, bus.cond_v, bus.cond_c});
    end
    tick();
    checks++;
    if ({bus.mem_valid, bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write} !== 4'b0000) begin
      errors++;
      $display("FAIL bubble_ctrl: got %b expected 0000",
               {bus.mem_valid, bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write});
    end
    checks++;
    if (bus.flag_n !== 1'b0 || bus.mem_result !== 64'h22 || bus.mem_rd !== 5'd6) begin
      errors++;
      $display("FAIL bubble_data: got flag_n=%b result=%h rd=%0d expected 0/22/6",
               bus.flag_n, bus.mem_result, bus.mem_rd);
    end
    $display("test_bubble done");
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    bus.ex_valid = 1; bus.ex_reg_write = 1; bus.ex_set_flags = 1;
    bus.ex_negative = 1; bus.ex_zero = 1; bus.ex_overflow = 1; bus.ex_carry_out = 1;
    bus.ex_result = 64'h33;
    tick();
    checks++;
    if ({bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== 4'b1111 || bus.mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got flags=%b valid=%b expected 1111/1",
               {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c}, bus.mem_valid);
    end
    reset = 1; bus.stall = 1; bus.flush = 1;
    tick();
    reset = 0; bus.stall = 0; bus.flush = 0; bus.ex_valid = 0;
    #1;
    checks++;
    if ({bus.mem_valid, bus.mem_reg_write, bus.mem_result} !== {2'b00, 64'h0} ||
        {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_clear: got valid=%b result=%h flags=%b expected 0/0/0000",
               bus.mem_valid, bus.mem_result, {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c});
    end
    checks++;
    if ({bus.cond_n, bus.cond_z, bus.cond_v, bus.cond_c} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_cond: got %b expected 0000", {bus.cond_n, bus.cond_z, bus.cond_v, bus.cond_c});
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      bus.ex_valid = 1; bus.ex_result = 64'h100 + 64'(i); bus.ex_rd = 5'(10 + i);
      bus.ex_mem_read = (i % 2 == 0); bus.ex_store_data = 64'hF0 + 64'(i);
      tick();
      checks++;
      if (bus.mem_result !== 64'h100 + 64'(i) || bus.mem_rd !== 5'(10 + i) ||
          bus.mem_store_data !== 64'hF0 + 64'(i) || bus.mem_mem_read !== (i % 2 == 0) ||
          bus.mem_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b[%0d]: got result=%h rd=%0d store=%h rd_en=%b expected %h/%0d/%h/%b",
                 i, bus.mem_result, bus.mem_rd, bus.mem_store_data, bus.mem_mem_read,
                 64'h100 + 64'(i), 10 + i, 64'hF0 + 64'(i), (i % 2 == 0));
      end
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1;
    idle_inputs();
    test_reset();
    test_load();
    test_flags_bypass();
    test_stall();
    test_flush_during_stall();
    test_bubble();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter DATA_W, default 64, width of the datapath (ALU result and store data).
REQ-002 Parameter REG_W, default 5, width of the destination register index.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 stall  input  1  hold all registered state this cycle.
REQ-006 flush  input  1  squash the instruction currently in EX.
REQ-007 ex_valid  input  1  EX holds a real instruction.
REQ-008 ex_result  input  DATA_W  ALU result.
REQ-009 ex_negative, ex_zero, ex_overflow, ex_carry_out  input  1 each  ALU flags.
REQ-010 ex_set_flags  input  1  instruction writes the condition flags (ADDS/SUBS).
REQ-011 ex_store_data  input  DATA_W  STUR data.
REQ-012 ex_rd  input  REG_W  destination register.
REQ-013 ex_reg_write, ex_mem_read, ex_mem_write  input  1 each  control bits.
REQ-014 mem_valid, mem_reg_write, mem_mem_read, mem_mem_write  output  1 each  registered EX/MEM control.
REQ-015 mem_result, mem_store_data  output  DATA_W  registered data.
REQ-016 mem_rd  output  REG_W  registered destination.
REQ-017 flag_n, flag_z, flag_v, flag_c  output  1 each  architectural flag register.
REQ-018 cond_n, cond_z, cond_v, cond_c  output  1 each  flags as seen by a B.cond in EX, bypass included.

Function
REQ-019 Per-edge priority SHALL be: reset > flush > stall > load.
REQ-020 Load (no reset, flush or stall): all mem_* outputs SHALL take the ex_* values one cycle after they are presented, with a latency of 1.
REQ-021 In a load, mem_valid SHALL equal ex_valid, and mem_reg_write, mem_mem_read and mem_mem_write SHALL each equal the ex_* bit ANDed with ex_valid.
REQ-022 Stall without flush: every register, including the flag register, SHALL hold its value.
REQ-023 Flush: mem_valid and all mem_* control bits SHALL clear to 0.
REQ-024 Flush: mem_result, mem_store_data and mem_rd SHALL clear to 0.
REQ-025 Flush: the flag register SHALL NOT update; flush SHALL override a simultaneous stall.
REQ-026 The flag register SHALL load {ex_negative, ex_zero, ex_overflow, ex_carry_out} only on an edge where ex_valid=1, ex_set_flags=1, stall=0, flush=0 and reset=0.
REQ-027 The flags SHALL otherwise retain their value indefinitely, with no wrap or decay.
REQ-028 cond_* SHALL be combinational: equal to ex_* flags when ex_valid=1 and ex_set_flags=1, else equal to flag_*.
REQ-029 cond_* SHALL be independent of stall and flush, so a flag-setter in EX is visible to the same cycle's B.cond.
REQ-030 No combinational path SHALL exist from any input to mem_* or flag_*.
REQ-031 Flags SHALL be passed through unmodified: no width conversion, and ex_overflow/ex_carry_out are stored as given regardless of operation.

Reset
REQ-032 On reset, mem_valid, mem_reg_write, mem_mem_read and mem_mem_write SHALL be 0.
REQ-033 On reset, mem_result and mem_store_data SHALL be 0, mem_rd SHALL be 0, and flag_n/z/v/c SHALL be 0.
REQ-034 Reset asserted mid-stream SHALL discard the in-flight instruction; the first load after deassertion SHALL behave as REQ-020.
REQ-035 Reset SHALL override stall and flush.

Verification
REQ-036 Load: ex_valid=1, ex_result=64'h5, ex_rd=3, ex_reg_write=1 -> next cycle mem_result=5, mem_rd=3, mem_reg_write=1, mem_valid=1.
REQ-037 Flag set and bypass: SUBS with ex_zero=1, ex_carry_out=1, ex_set_flags=1 -> same cycle cond_z=1, cond_c=1; next cycle flag_z=1, flag_c=1; then an ADD with ex_set_flags=0 and ex_zero=0 -> flag_z stays 1.
REQ-038 Stall: stall=1 for 3 cycles while ex_result changes 7->8->9 -> mem_result holds its prior value 5 and flags unchanged; stall=0 -> mem_result=9.
REQ-039 Flush during stall: stall=1, flush=1 with a valid ex_mem_write=1 flag-setter -> next cycle mem_valid=0, mem_mem_write=0, mem_result=0, flag_* unchanged.
REQ-040 Invalid bubble: ex_valid=0, ex_reg_write=1, ex_set_flags=1, ex_negative=1 -> mem_reg_write=0, flag_n unchanged, cond_n=flag_n.
REQ-041 Reset mid-operation: flags = 4'b1111 and mem_valid=1, reset=1 for one edge -> all outputs 0, cond_*=0 while ex_valid=0.
